// File: rtl/color_sampler_if.sv
// rtl/color_sampler_if.sv - request/result bundle between a host and color_sampler
interface color_sampler_if;
   logic       start;
   logic       valid;
   logic       busy;
   logic [7:0] r_edge;
   logic [7:0] g_edge;
   logic [7:0] b_edge;
   logic [7:0] r_corner;
   logic [7:0] g_corner;
   logic [7:0] b_corner;

   modport master (
      output start,
      input  valid, busy,
      input  r_edge, g_edge, b_edge,
      input  r_corner, g_corner, b_corner
   );

   modport slave (
      input  start,
      output valid, busy,
      output r_edge, g_edge, b_edge,
      output r_corner, g_corner, b_corner
   );
endinterface

// File: rtl/color_sampler.sv
// rtl/color_sampler.sv - sequences S2/S3 through R/G/B, gates pulse counts from two
// colour sensors and publishes six scaled readings as one coherent set.
module color_sampler #(
   parameter int GATE_CYCLES   = 65000,
   parameter int SETTLE_CYCLES = 6500,
   parameter int CNT_W         = 16,
   parameter int SHIFT         = 4
)(
   input  logic clock,
   input  logic reset_n,
   input  logic freq_edge,
   input  logic freq_corner,
   output logic s2,
   output logic s3,
   color_sampler_if.slave bus
);

   localparam int MAXC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
   localparam int TW   = $clog2(MAXC + 1);

   localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0]    GATE_LAST   = TW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_COUNT  = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam logic [1:0] C_RED   = 2'd0;
   localparam logic [1:0] C_GREEN = 2'd1;
   localparam logic [1:0] C_BLUE  = 2'd2;

   localparam logic [1:0] F_RED   = 2'b00;
   localparam logic [1:0] F_GREEN = 2'b11;
   localparam logic [1:0] F_BLUE  = 2'b01;
   localparam logic [1:0] F_CLEAR = 2'b10;

   logic [1:0]       state;
   logic [1:0]       colour;
   logic [1:0]       filt;
   logic [TW-1:0]    timer;
   logic [2:0]       sync_e;
   logic [2:0]       sync_c;
   logic [CNT_W-1:0] cnt_e;
   logic [CNT_W-1:0] cnt_c;
   logic [CNT_W-1:0] cnt_e_next;
   logic [CNT_W-1:0] cnt_c_next;
   logic             rise_e;
   logic             rise_c;
   logic [7:0]       hold_r_e, hold_g_e, hold_r_c, hold_g_c;

   function automatic logic [7:0] scale(input logic [CNT_W-1:0] c);
      logic [31:0] w;
      w = 32'(c) >> SHIFT;
      return (w > 32'd255) ? 8'hFF : w[7:0];
   endfunction

   assign s2 = filt[1];
   assign s3 = filt[0];

   // bits [1:0] are the synchronizer, bit 2 remembers the previous level
   assign rise_e = sync_e[1] & ~sync_e[2];
   assign rise_c = sync_c[1] & ~sync_c[2];

   always_comb begin
      cnt_e_next = cnt_e;
      cnt_c_next = cnt_c;
      if (rise_e && (cnt_e != CNT_MAX)) cnt_e_next = cnt_e + CNT_W'(1);
      if (rise_c && (cnt_c != CNT_MAX)) cnt_c_next = cnt_c + CNT_W'(1);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_e <= 3'b000;
         sync_c <= 3'b000;
      end else begin
         sync_e <= {sync_e[1:0], freq_edge};
         sync_c <= {sync_c[1:0], freq_corner};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         colour       <= C_RED;
         filt         <= F_CLEAR;
         timer        <= '0;
         cnt_e        <= '0;
         cnt_c        <= '0;
         hold_r_e     <= 8'd0;
         hold_g_e     <= 8'd0;
         hold_r_c     <= 8'd0;
         hold_g_c     <= 8'd0;
         bus.valid    <= 1'b0;
         bus.busy     <= 1'b0;
         bus.r_edge   <= 8'd0;
         bus.g_edge   <= 8'd0;
         bus.b_edge   <= 8'd0;
         bus.r_corner <= 8'd0;
         bus.g_corner <= 8'd0;
         bus.b_corner <= 8'd0;
      end else begin
         bus.valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  state    <= ST_SETTLE;
                  colour   <= C_RED;
                  filt     <= F_RED;
                  bus.busy <= 1'b1;
                  timer    <= '0;
               end
            end
            ST_SETTLE: begin
               cnt_e <= '0;
               cnt_c <= '0;
               if (timer == SETTLE_LAST) begin
                  timer <= '0;
                  state <= ST_COUNT;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            ST_COUNT: begin
               if (timer == GATE_LAST) begin
                  timer <= '0;
                  cnt_e <= '0;
                  cnt_c <= '0;
                  case (colour)
                     C_RED: begin
                        hold_r_e <= scale(cnt_e_next);
                        hold_r_c <= scale(cnt_c_next);
                        colour   <= C_GREEN;
                        filt     <= F_GREEN;
                        state    <= ST_SETTLE;
                     end
                     C_GREEN: begin
                        hold_g_e <= scale(cnt_e_next);
                        hold_g_c <= scale(cnt_c_next);
                        colour   <= C_BLUE;
                        filt     <= F_BLUE;
                        state    <= ST_SETTLE;
                     end
                     default: begin
                        // blue goes straight to the outputs so all six appear together in DONE
                        bus.r_edge   <= hold_r_e;
                        bus.g_edge   <= hold_g_e;
                        bus.b_edge   <= scale(cnt_e_next);
                        bus.r_corner <= hold_r_c;
                        bus.g_corner <= hold_g_c;
                        bus.b_corner <= scale(cnt_c_next);
                        bus.valid    <= 1'b1;
                        filt         <= F_CLEAR;
                        state        <= ST_DONE;
                     end
                  endcase
               end else begin
                  cnt_e <= cnt_e_next;
                  cnt_c <= cnt_c_next;
                  timer <= timer + TW'(1);
               end
            end
            default: begin
               state    <= ST_IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_color_sampler.sv
// tb/tb_color_sampler.sv - directed checks of filter sequencing, timing, separation,
// saturation, ignored starts and mid-measurement reset.
module tb_color_sampler;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset_n;
   logic sq4, sq8;
   logic gated;
   logic m_s2, m_s3, s8_s2, s8_s3, s7_s2, s7_s3;
   logic fe, fc;

   initial begin sq4 = 1'b0; #2; forever #20 sq4 = ~sq4; end
   initial begin sq8 = 1'b0; #2; forever #40 sq8 = ~sq8; end

   assign fe = gated ? (sq4 & ({m_s2, m_s3} == 2'b00)) : sq4;
   assign fc = gated ? (sq8 & ({m_s2, m_s3} == 2'b01)) : sq4;

   color_sampler_if bus_m();
   color_sampler_if bus_s8();
   color_sampler_if bus_s7();

   color_sampler #(.GATE_CYCLES(100), .SETTLE_CYCLES(10), .CNT_W(16), .SHIFT(2)) dut_m (
      .clock(clock), .reset_n(reset_n), .freq_edge(fe), .freq_corner(fc),
      .s2(m_s2), .s3(m_s3), .bus(bus_m));
   color_sampler #(.GATE_CYCLES(1000), .SETTLE_CYCLES(10), .CNT_W(8), .SHIFT(0)) dut_s8 (
      .clock(clock), .reset_n(reset_n), .freq_edge(sq4), .freq_corner(sq4),
      .s2(s8_s2), .s3(s8_s3), .bus(bus_s8));
   color_sampler #(.GATE_CYCLES(1000), .SETTLE_CYCLES(10), .CNT_W(7), .SHIFT(0)) dut_s7 (
      .clock(clock), .reset_n(reset_n), .freq_edge(sq4), .freq_corner(sq4),
      .s2(s7_s2), .s3(s7_s3), .bus(bus_s7));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   function automatic int rd(input int which, input int k);
      logic [7:0] v;
      v = 8'd0;
      case (which)
         0: case (k) 0: v = bus_m.r_edge;  1: v = bus_m.g_edge;  2: v = bus_m.b_edge;
                     3: v = bus_m.r_corner; 4: v = bus_m.g_corner; default: v = bus_m.b_corner; endcase
         1: case (k) 0: v = bus_s8.r_edge;  1: v = bus_s8.g_edge;  2: v = bus_s8.b_edge;
                     3: v = bus_s8.r_corner; 4: v = bus_s8.g_corner; default: v = bus_s8.b_corner; endcase
         default: case (k) 0: v = bus_s7.r_edge;  1: v = bus_s7.g_edge;  2: v = bus_s7.b_edge;
                     3: v = bus_s7.r_corner; 4: v = bus_s7.g_corner; default: v = bus_s7.b_corner; endcase
      endcase
      return int'(v);
   endfunction

   typedef struct {
      int         cyc;
      logic [1:0] s23;
      logic       busy;
      logic       valid;
   } vec_t;

   vec_t tbl[10];
   int   exp_sep[6];
   int   vcount, vcyc;

   initial begin
      tbl[0] = '{1,   2'b00, 1'b1, 1'b0};
      tbl[1] = '{10,  2'b00, 1'b1, 1'b0};
      tbl[2] = '{110, 2'b00, 1'b1, 1'b0};
      tbl[3] = '{111, 2'b11, 1'b1, 1'b0};
      tbl[4] = '{220, 2'b11, 1'b1, 1'b0};
      tbl[5] = '{221, 2'b01, 1'b1, 1'b0};
      tbl[6] = '{330, 2'b01, 1'b1, 1'b0};
      tbl[7] = '{331, 2'b10, 1'b1, 1'b1};
      tbl[8] = '{332, 2'b10, 1'b0, 1'b0};
      tbl[9] = '{340, 2'b10, 1'b0, 1'b0};
      exp_sep = '{6, 0, 0, 0, 0, 3};

      gated = 1'b0;
      bus_m.start = 1'b0;
      bus_s8.start = 1'b0;
      bus_s7.start = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clock);

      // reset state
      check("rst_s2s3", int'({m_s2, m_s3}), 2);
      check("rst_busy", int'(bus_m.busy), 0);
      check("rst_valid", int'(bus_m.valid), 0);
      for (int k = 0; k < 6; k++) check($sformatf("rst_rd%0d", k), rd(0, k), 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // nominal timing and filter sequencing
      bus_m.start = 1'b1;
      vcount = 0; vcyc = -1;
      for (int n = 1; n <= 340; n++) begin
         @(negedge clock);
         if (n == 1) bus_m.start = 1'b0;
         if (bus_m.valid) begin vcount++; vcyc = n; end
         for (int i = 0; i < 10; i++) begin
            if (tbl[i].cyc == n) begin
               check($sformatf("seq_s2s3_c%0d", n), int'({m_s2, m_s3}), int'(tbl[i].s23));
               check($sformatf("seq_busy_c%0d", n), int'(bus_m.busy), int'(tbl[i].busy));
               check($sformatf("seq_valid_c%0d", n), int'(bus_m.valid), int'(tbl[i].valid));
            end
         end
      end
      check("nom_valid_count", vcount, 1);
      check("nom_valid_cycle", vcyc, 331);
      for (int k = 0; k < 6; k++) check($sformatf("nom_rd%0d", k), rd(0, k), 6);

      // per-colour and per-sensor separation
      gated = 1'b1;
      bus_m.start = 1'b1;
      vcount = 0;
      for (int n = 1; n <= 340; n++) begin
         @(negedge clock);
         if (n == 1) bus_m.start = 1'b0;
         if (bus_m.valid) vcount++;
      end
      check("sep_valid_count", vcount, 1);
      for (int k = 0; k < 6; k++) check($sformatf("sep_rd%0d", k), rd(0, k), exp_sep[k]);
      gated = 1'b0;

      // starts while busy and during DONE are ignored
      bus_m.start = 1'b1;
      vcount = 0; vcyc = -1;
      for (int n = 1; n <= 700; n++) begin
         @(negedge clock);
         bus_m.start = (n == 50 || n == 331);
         if (bus_m.valid) begin vcount++; vcyc = n; end
         if (n == 331) check("rs_busy_331", int'(bus_m.busy), 1);
         if (n == 332) check("rs_busy_332", int'(bus_m.busy), 0);
         if (n == 400) check("rs_busy_400", int'(bus_m.busy), 0);
      end
      check("rs_valid_count", vcount, 1);
      check("rs_valid_cycle", vcyc, 331);

      // reset mid-measurement, then a fresh start
      bus_m.start = 1'b1;
      vcount = 0; vcyc = -1;
      for (int n = 1; n <= 510; n++) begin
         @(negedge clock);
         bus_m.start = (n == 170);
         if (n == 150) reset_n = 1'b0;
         if (n == 160) reset_n = 1'b1;
         if (bus_m.valid) begin vcount++; vcyc = n; end
         if (n == 155) begin
            check("mr_s2s3", int'({m_s2, m_s3}), 2);
            check("mr_busy", int'(bus_m.busy), 0);
            for (int k = 0; k < 6; k++) check($sformatf("mr_rd%0d", k), rd(0, k), 0);
         end
         if (n == 165) check("mr_idle_s2s3", int'({m_s2, m_s3}), 2);
      end
      check("mr_valid_count", vcount, 1);
      check("mr_valid_cycle", vcyc, 501);
      check("mr_rd_after", rd(0, 0), 6);

      // counter saturation with narrow counters
      bus_s8.start = 1'b1;
      bus_s7.start = 1'b1;
      vcyc = -1;
      for (int n = 1; n <= 3100 && vcyc < 0; n++) begin
         @(negedge clock);
         bus_s8.start = 1'b0;
         bus_s7.start = 1'b0;
         if (bus_s8.valid) vcyc = n;
      end
      check("sat_valid_cycle", vcyc, 3031);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("sat8_rd%0d", k), rd(1, k), 250);
         check($sformatf("sat7_rd%0d", k), rd(2, k), 127);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
